// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline payload register with load / bubble / hold controls.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t data_i,
    output if_id_t data_o
);

    if_id_t data_d;
    if_id_t data_q;

    // A bubble keeps the old pc so pc_o/pc4_o stay stable; it beats load.
    always_comb begin
        // NOTE: default-assign every always_comb output first so no path infers a latch.
        data_d = data_q;
        if (bubble_i) begin
            data_d.inst  = NOP_INST;
            data_d.valid = 1'b0;
        end else if (load_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '{inst: NOP_INST, pc: RESET_PC, valid: 1'b0};
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, runs the icache req/ack handshake and
// drives the IF/ID register, honouring stall (hazard unit) and flush (execute).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_ack_i,
    input  logic [31:0] icache_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o,
    output logic [31:0] fetch_stall_cnt_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redir_q, redir_d;
    if_id_t       buf_q, buf_d;
    logic         req_q, req_d;
    logic [31:0]  cnt_q, cnt_d;

    logic         ifid_load;
    logic         ifid_bubble;
    if_id_t       ifid_in;
    if_id_t       ifid_out;
    logic [31:0]  target;

    assign target = word_align(redirect_pc_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        buf_d       = buf_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_in     = buf_q;

        unique case (state_q)
            BOOT: state_d = FETCH;

            FETCH: begin
                if (flush_i) begin
                    ifid_bubble = 1'b1;
                    if (icache_ack_i) begin
                        pc_d = target;
                    end else begin
                        // Request still outstanding: park the target until it completes.
                        redir_d = target;
                        state_d = DRAIN;
                    end
                end else if (icache_ack_i) begin
                    pc_d = pc_q + 32'd4;
                    if (stall_i) begin
                        buf_d   = '{inst: icache_rdata_i, pc: pc_q, valid: 1'b1};
                        state_d = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        ifid_in   = '{inst: icache_rdata_i, pc: pc_q, valid: 1'b1};
                    end
                end else if (!stall_i) begin
                    ifid_bubble = 1'b1;
                end
            end

            HOLD: begin
                if (flush_i) begin
                    ifid_bubble = 1'b1;
                    pc_d        = target;
                    state_d     = FETCH;
                end else if (!stall_i) begin
                    ifid_load = 1'b1;
                    state_d   = FETCH;
                end
            end

            DRAIN: begin
                ifid_bubble = 1'b1;
                if (flush_i) begin
                    redir_d = target;
                end
                if (icache_ack_i) begin
                    pc_d    = flush_i ? target : redir_q;
                    state_d = FETCH;
                end
            end

            default: state_d = BOOT;
        endcase

        req_d = (state_d == FETCH) || (state_d == DRAIN);
        cnt_d = (req_q && !icache_ack_i && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            redir_q <= RESET_PC;
            buf_q   <= '{inst: NOP_INST, pc: RESET_PC, valid: 1'b0};
            req_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            buf_q   <= buf_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .data_i   (ifid_in),
        .data_o   (ifid_out)
    );

    assign icache_req_o      = req_q;
    assign icache_addr_o     = word_align(pc_q);
    assign inst_o            = ifid_out.inst;
    assign pc_o              = ifid_out.pc;
    assign pc4_o             = ifid_out.pc + 32'd4;
    assign valid_o           = ifid_out.valid;
    assign fetch_stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] redir;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .stall_i           (stall),
        .flush_i           (flush),
        .redirect_pc_i     (redir),
        .icache_req_o      (req),
        .icache_addr_o     (addr),
        .icache_ack_i      (ack),
        .icache_rdata_i    (rdata),
        .inst_o            (inst),
        .pc_o              (pc),
        .pc4_o             (pc4),
        .valid_o           (valid),
        .fetch_stall_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, then advance to just after the next rising edge.
    task automatic cyc(input logic s, input logic f, input logic a,
                       input logic [31:0] rd, input logic [31:0] rp);
        stall = s; flush = f; ack = a; rdata = rd; redir = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req"},   {31'd0, req},   32'd0);
        check({tag, " addr"},  addr,           32'h0);
        check({tag, " inst"},  inst,           NOP);
        check({tag, " pc"},    pc,             32'h0);
        check({tag, " pc4"},   pc4,            32'h4);
        check({tag, " valid"}, {31'd0, valid}, 32'd0);
        check({tag, " cnt"},   cnt,            32'd0);
    endtask

    // Leaves the bench just after an edge with rst_n high: the DUT is in its boot cycle.
    task automatic apply_reset(input bit do_check);
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; ack = 1'b0; rdata = '0; redir = '0;
        repeat (2) @(posedge clk);
        #1;
        if (do_check) check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        stall, flush, ack;
        logic [31:0] rdata, redir;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst, exp_pc, exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic f, input logic a,
                       input logic [31:0] rd, input logic [31:0] rp,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ec);
        vec_t v;
        v = '{s, f, a, rd, rp, er, ea, ev, ei, ep, ec};
        tbl.push_back(v);
    endtask

    // Reference model state: issue pointer, parked response buffer, pending redirect.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } held_t;

    bit          m_started;
    logic [31:0] m_pc;
    held_t       m_held[$];
    bit          m_drop;
    logic [31:0] m_target;
    logic [31:0] m_inst, m_pc_o, m_cnt;
    logic        m_valid;

    task automatic model_reset();
        m_started = 0; m_pc = 32'h0; m_held.delete(); m_drop = 0; m_target = 32'h0;
        m_inst = NOP; m_pc_o = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic a,
                              input logic [31:0] rd, input logic [31:0] rp);
        logic        busy;
        logic [31:0] tgt;
        tgt  = rp & 32'hFFFF_FFFC;
        busy = m_started && (m_held.size() == 0);
        if (busy && !a && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!m_started) begin
            m_started = 1;
        end else if (m_held.size() != 0) begin
            if (f) begin
                m_held.delete(); m_pc = tgt; m_inst = NOP; m_valid = 0;
            end else if (!s) begin
                m_inst = m_held[0].inst; m_pc_o = m_held[0].pc; m_valid = 1;
                m_held.delete();
            end
        end else if (m_drop) begin
            m_inst = NOP; m_valid = 0;
            if (f) m_target = tgt;
            if (a) begin m_pc = m_target; m_drop = 0; end
        end else if (f) begin
            m_inst = NOP; m_valid = 0;
            if (a) m_pc = tgt;
            else begin m_drop = 1; m_target = tgt; end
        end else if (a) begin
            if (s) m_held.push_back('{inst: rd, pc: m_pc});
            else begin m_inst = rd; m_pc_o = m_pc; m_valid = 1; end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_inst = NOP; m_valid = 0;
        end
    endtask

    initial begin
        // Directed table: same-cycle hits, a 3-cycle miss at 0x10, then a 2-cycle stall.
        add(0,0,0,32'h0,       0, 0,32'h00,0,NOP,         32'h00,0);
        add(0,0,1,32'hA000_0000,0,1,32'h00,0,NOP,         32'h00,0);
        add(0,0,1,32'hA000_0001,0,1,32'h04,1,32'hA000_0000,32'h00,0);
        add(0,0,1,32'hA000_0002,0,1,32'h08,1,32'hA000_0001,32'h04,0);
        add(0,0,1,32'hA000_0003,0,1,32'h0C,1,32'hA000_0002,32'h08,0);
        add(0,0,0,32'h0,       0, 1,32'h10,1,32'hA000_0003,32'h0C,0);
        add(0,0,0,32'h0,       0, 1,32'h10,0,NOP,         32'h0C,1);
        add(0,0,0,32'h0,       0, 1,32'h10,0,NOP,         32'h0C,2);
        add(0,0,1,32'hB000_0004,0,1,32'h10,0,NOP,         32'h0C,3);
        add(1,0,1,32'hB000_0005,0,1,32'h14,1,32'hB000_0004,32'h10,3);
        add(1,0,0,32'h0,       0, 0,32'h18,1,32'hB000_0004,32'h10,3);
        add(0,0,0,32'h0,       0, 0,32'h18,1,32'hB000_0004,32'h10,3);
        add(0,0,1,32'hB000_0006,0,1,32'h18,1,32'hB000_0005,32'h14,3);
        add(0,0,0,32'h0,       0, 1,32'h1C,1,32'hB000_0006,32'h18,3);

        apply_reset(1);
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            check({tag, " req"}, {31'd0, req}, {31'd0, tbl[i].exp_req});
            if (tbl[i].exp_req) check({tag, " addr"}, addr, tbl[i].exp_addr);
            check({tag, " valid"}, {31'd0, valid}, {31'd0, tbl[i].exp_valid});
            check({tag, " inst"}, inst, tbl[i].exp_inst);
            check({tag, " pc"}, pc, tbl[i].exp_pc);
            check({tag, " pc4"}, pc4, tbl[i].exp_pc + 32'd4);
            check({tag, " cnt"}, cnt, tbl[i].exp_cnt);
            cyc(tbl[i].stall, tbl[i].flush, tbl[i].ack, tbl[i].rdata, tbl[i].redir);
        end

        // Double flush while the request to 0x40 is outstanding: newest target wins.
        apply_reset(0);
        cyc(0,0,0,32'h0,32'h0);
        cyc(0,1,1,32'hDEAD_0000,32'h40);
        check("dr addr0", addr, 32'h40);
        cyc(0,1,0,32'h0,32'h200);
        check("dr req", {31'd0, req}, 32'd1);
        check("dr addr1", addr, 32'h40);
        check("dr valid1", {31'd0, valid}, 32'd0);
        cyc(0,1,0,32'h0,32'h300);
        check("dr addr2", addr, 32'h40);
        check("dr valid2", {31'd0, valid}, 32'd0);
        cyc(0,0,1,32'hDEAD_BEEF,32'h0);
        check("dr addr3", addr, 32'h300);
        check("dr valid3", {31'd0, valid}, 32'd0);
        check("dr inst3", inst, NOP);
        check("dr cnt", cnt, 32'd2);
        cyc(0,0,1,32'hC000_0007,32'h0);
        check("dr inst4", inst, 32'hC000_0007);
        check("dr pc4", pc, 32'h300);

        // Flush and stall together while holding a buffered instruction.
        apply_reset(0);
        cyc(0,0,0,32'h0,32'h0);
        cyc(1,0,1,32'hC000_0008,32'h0);
        check("hold req", {31'd0, req}, 32'd0);
        check("hold valid", {31'd0, valid}, 32'd0);
        cyc(1,1,0,32'h0,32'h500);
        check("hf req", {31'd0, req}, 32'd1);
        check("hf addr", addr, 32'h500);
        check("hf inst", inst, NOP);
        check("hf valid", {31'd0, valid}, 32'd0);
        cyc(0,0,1,32'hC000_0009,32'h0);
        check("hf inst2", inst, 32'hC000_0009);
        check("hf pc2", pc, 32'h500);

        // Unaligned redirect to the top word, then PC wrap to zero.
        apply_reset(0);
        cyc(0,0,0,32'h0,32'h0);
        cyc(0,1,1,32'h0,32'hFFFF_FFFF);
        check("wrap addr0", addr, 32'hFFFF_FFFC);
        cyc(0,0,1,32'hC000_000A,32'h0);
        check("wrap addr1", addr, 32'h0);
        check("wrap pc", pc, 32'hFFFF_FFFC);
        check("wrap pc4", pc4, 32'h0);
        check("wrap inst", inst, 32'hC000_000A);

        // Enter DRAIN with non-reset outputs, then assert reset mid-cycle.
        cyc(0,0,1,32'hC000_000B,32'h0);
        cyc(0,0,1,32'hC000_000C,32'h0);
        cyc(0,1,0,32'h0,32'h80);
        check("pre-rst addr", addr, 32'h8);
        check("pre-rst pc", pc, 32'h4);
        check("pre-rst cnt", cnt, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async-rst");

        // Random traffic against the reference model.
        apply_reset(0);
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        s, f, a;
            logic [31:0] rd, rp;
            logic        e_req;
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 2) != 0);
            rd = $urandom;
            rp = $urandom;
            e_req = m_started && (m_held.size() == 0);
            check("rnd req", {31'd0, req}, {31'd0, e_req});
            if (e_req) check("rnd addr", addr, m_pc);
            check("rnd valid", {31'd0, valid}, {31'd0, m_valid});
            check("rnd inst", inst, m_inst);
            check("rnd pc", pc, m_pc_o);
            check("rnd pc4", pc4, m_pc_o + 32'd4);
            check("rnd cnt", cnt, m_cnt);
            model_step(s, f, a, rd, rp);
            cyc(s, f, a, rd, rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline. It owns the program counter, issues requests to the instruction cache over a request/acknowledge handshake, and drives the IF/ID pipeline register whose instruction output feeds the decode/control unit. Stall requests come from the hazard unit, which detects load-use conditions from the decoder's load flag. Flush and redirect requests come from the execute stage when a branch is taken or a JAL/JALR executes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk_i  in  1  clock; single clock domain, all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- stall_i  in  1  hold the IF/ID register and the PC (load-use hazard)
- flush_i  in  1  discard the in-flight fetch, insert a bubble, fetch from redirect_pc_i
- redirect_pc_i  in  32  branch/jump target, sampled only when flush_i=1
- icache_req_o  out  1  fetch request
- icache_addr_o  out  32  fetch address, word aligned
- icache_ack_i  in  1  icache_rdata_i is valid this cycle and the request completes
- icache_rdata_i  in  32  fetched instruction
- inst_o  out  32  IF/ID instruction, goes to the decoder
- pc_o  out  32  IF/ID PC of inst_o
- pc4_o  out  32  pc_o + 4, the JAL/JALR link value
- valid_o  out  1  inst_o is a real instruction (0 = bubble)
- fetch_stall_cnt_o  out  32  count of cycles spent waiting on the cache

## Operation
- State machine states: BOOT, FETCH, HOLD, DRAIN.
- **BOOT** (reset state):
  - icache_req_o=0.
  - Always moves to FETCH on the next cycle.
- **FETCH**:
  - icache_req_o=1 and icache_addr_o=pc_q. The address stays stable until the acknowledge arrives.
  - flush_i and ack together: drop the returned data, pc_q<=redirect_pc_i, IF/ID<=bubble, stay in FETCH.
  - flush_i without ack: redir_q<=redirect_pc_i, IF/ID<=bubble, go to DRAIN.
  - ack with stall_i=0: IF/ID<={icache_rdata_i, pc_q, valid=1}, pc_q<=pc_q+4.
  - ack with stall_i=1: buf_q<={icache_rdata_i, pc_q}, pc_q<=pc_q+4, IF/ID held, go to HOLD.
  - No ack and stall_i=0: IF/ID<=bubble.
  - No ack and stall_i=1: IF/ID held.
- **HOLD**:
  - icache_req_o=0.
  - flush_i: discard buf_q, pc_q<=redirect_pc_i, IF/ID<=bubble, go to FETCH.
  - stall_i=0: IF/ID<={buf_q, valid=1}, go to FETCH.
  - Otherwise stay in HOLD.
- **DRAIN**:
  - icache_req_o=1 with the old pc_q, to complete the outstanding request.
  - A new flush_i overwrites redir_q with the newest target. The newest target always wins.
  - On ack: drop the returned data, pc_q<=redir_q (or redirect_pc_i if flush_i is asserted in the same cycle), go to FETCH.
  - IF/ID outputs a bubble throughout.
- Priority: flush_i takes precedence over stall_i in every state.
- Bubble definition: inst_o=NOP_INST, valid_o=0, pc_o and pc4_o keep their previous values.
- Width and arithmetic rules:
  - PC increment is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - icache_addr_o[1:0] is forced to 0, as are the low two bits of redirect_pc_i.
- fetch_stall_cnt_o:
  - Increments in any cycle where icache_req_o=1 and icache_ack_i=0.
  - Saturates at 32'hFFFF_FFFF.
  - Reset value is 0.

## Timing
- Reset values (asynchronous, while rst_ni=0):
  - state=BOOT, pc_q=RESET_PC, icache_req_o=0, icache_addr_o=RESET_PC.
  - inst_o=NOP_INST, pc_o=RESET_PC, pc4_o=RESET_PC+4, valid_o=0, fetch_stall_cnt_o=0.
- After reset release: one BOOT cycle, then the first request.
- Hit latency:
  - An acknowledge in cycle t puts the instruction on inst_o from cycle t+1.
  - Throughput is one instruction per cycle when every request is acknowledged in the same cycle.
- Handshake rules:
  - The cache may acknowledge in the request cycle or any later cycle.
  - icache_addr_o must not change while icache_req_o=1 and icache_ack_i=0, even across a flush.
- Redirect latency:
  - A flush in cycle t with no request outstanding (ack in t, or state HOLD) issues redirect_pc_i in cycle t+1.
  - Otherwise the redirect is issued the cycle after the outstanding acknowledge.
- Reset asserted mid-operation: all state clears immediately, and any outstanding request is abandoned.

## Structure
- fetch_pkg holds:
  - the state enum (BOOT, FETCH, HOLD, DRAIN)
  - the NOP_INST constant
  - the IF/ID payload struct {inst, pc, valid}
- Sub-module if_id_reg (IF/ID payload register with load/bubble/hold controls) is natural and can be reused for the later pipeline registers.

## Test plan
- Reset, then the cache acknowledges every request in the same cycle -> addresses 0,4,8,12 on consecutive cycles; inst_o follows one cycle later with valid_o=1; fetch_stall_cnt_o=0.
- Acknowledge 3 cycles after the request, for address 0x10 -> address stays 0x10 for 4 cycles; valid_o=0 during the wait; fetch_stall_cnt_o=3.
- Acknowledge with stall_i=1 for 2 cycles -> inst_o holds; icache_req_o=0 in HOLD; the buffered instruction appears when stall_i falls; the next request is to pc+4.
- flush_i with redirect_pc_i=0x200 while the request to 0x40 is pending, then a second flush to 0x300, then ack -> the data for 0x40 is dropped; the next address is 0x300; valid_o=0 throughout.
- flush_i and stall_i together in HOLD -> buffer discarded, bubble output, next address is redirect_pc_i.
- pc_q=32'hFFFF_FFFC acknowledged -> next address is 0; rst_ni dropped mid-DRAIN -> all outputs return to their reset values immediately.
